// File: rtl/div_unit_if.sv
// -----------------------------------------------------------------------------
// div_unit_if
// Handshake bundle between the EX stage and the multi-cycle RV32M divider.
//
//   start_i     request a division (sampled only while the divider is idle)
//   op_i        00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend_i  rs1 value
//   divisor_i   rs2 value
//   rd_addr_i   destination register of the request
//   flush_i     abort the operation in flight
//   hold_req_o  pipeline hold request towards the controller
//   busy_o      divider is not idle
//   valid_o     result_o / rd_addr_o are valid this cycle
//   result_o    quotient or remainder
//   rd_addr_o   destination register of result_o
//
// master: the EX stage driving requests; slave: the divider itself.
// -----------------------------------------------------------------------------
interface div_unit_if #(
    parameter int XLEN = 32
);
    logic              start_i;
    logic [1:0]        op_i;
    logic [XLEN-1:0]   dividend_i;
    logic [XLEN-1:0]   divisor_i;
    logic [4:0]        rd_addr_i;
    logic              flush_i;
    logic              hold_req_o;
    logic              busy_o;
    logic              valid_o;
    logic [XLEN-1:0]   result_o;
    logic [4:0]        rd_addr_o;

    modport master (
        output start_i,
        output op_i,
        output dividend_i,
        output divisor_i,
        output rd_addr_i,
        output flush_i,
        input  hold_req_o,
        input  busy_o,
        input  valid_o,
        input  result_o,
        input  rd_addr_o
    );

    modport slave (
        input  start_i,
        input  op_i,
        input  dividend_i,
        input  divisor_i,
        input  rd_addr_i,
        input  flush_i,
        output hold_req_o,
        output busy_o,
        output valid_o,
        output result_o,
        output rd_addr_o
    );
endinterface

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
// Multi-cycle RV32M divider (DIV, DIVU, REM, REMU) living in the EX stage.
//
// A request accepted in IDLE either resolves immediately (divide by zero or
// signed overflow, result one cycle later) or runs 32 restoring-division
// steps in CALC, one per cycle, followed by a single DONE cycle in which
// valid_o is raised. While the request is accepted and during CALC the unit
// asks the pipeline controller to hold the front of the pipe.
//
// Ports:
//   clk   clock, rising edge
//   rstn  reset, synchronous, active-low
//   bus   div_unit_if.slave: request inputs, hold/busy/valid/result outputs
// -----------------------------------------------------------------------------
module div_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic          clk,
    input  logic          rstn,
    div_unit_if.slave     bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Two's-complement negation when neg is set, pass-through otherwise.
    function automatic logic [XLEN-1:0] neg_cond(input logic [XLEN-1:0] v,
                                                 input logic            neg);
        logic [XLEN-1:0] r;
        if (neg) begin
            r = ~v + {{(XLEN-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    localparam logic [XLEN-1:0]  ZERO_W     = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]  ONES_W     = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]  MIN_NEG_W  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    // ---------------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------------
    state_t              state_r;
    state_t              state_nxt_s;
    logic [1:0]          op_r;
    logic [4:0]          rd_addr_r;
    logic                sign_dvd_r;
    logic                sign_dvs_r;
    logic [XLEN-1:0]     divisor_r;
    logic [2*XLEN-1:0]   shreg_r;      // {remainder, quotient}
    logic [CNT_W-1:0]    cnt_r;
    logic [XLEN-1:0]     result_r;
    logic [4:0]          rd_out_r;

    // ---------------------------------------------------------------------
    // Request decode (IDLE-side combinational signals)
    // ---------------------------------------------------------------------
    logic                op_signed_s;
    logic                op_rem_s;
    logic                dvd_neg_s;
    logic                dvs_neg_s;
    logic [XLEN-1:0]     dvd_abs_s;
    logic [XLEN-1:0]     dvs_abs_s;
    logic                div_zero_s;
    logic                overflow_s;
    logic                start_acc_s;
    logic [XLEN-1:0]     special_res_s;

    // Decode the incoming request: signedness, magnitudes and special cases.
    always_comb begin
        op_signed_s = ~bus.op_i[0];
        op_rem_s    = bus.op_i[1];
        // Only DIV/REM take magnitudes; unsigned ops see the raw operands.
        dvd_neg_s   = op_signed_s & bus.dividend_i[XLEN-1];
        dvs_neg_s   = op_signed_s & bus.divisor_i[XLEN-1];
        dvd_abs_s   = neg_cond(bus.dividend_i, dvd_neg_s);
        dvs_abs_s   = neg_cond(bus.divisor_i, dvs_neg_s);
        div_zero_s  = (bus.divisor_i == ZERO_W);
        overflow_s  = op_signed_s && (bus.dividend_i == MIN_NEG_W) &&
                      (bus.divisor_i == ONES_W);
        start_acc_s = (state_r == ST_IDLE) && bus.start_i && !bus.flush_i;
        if (div_zero_s) begin
            // Quotient is all ones for both signednesses; remainder is the
            // untouched dividend (not its magnitude).
            special_res_s = op_rem_s ? bus.dividend_i : ONES_W;
        end else begin
            special_res_s = op_rem_s ? ZERO_W : MIN_NEG_W;
        end
    end

    // ---------------------------------------------------------------------
    // One restoring step and the final result selection
    // ---------------------------------------------------------------------
    logic [XLEN:0]       rem_shift_s;
    logic [XLEN:0]       trial_s;
    logic                step_ok_s;
    logic [XLEN-1:0]     rem_next_s;
    logic [XLEN-1:0]     quo_next_s;
    logic [XLEN-1:0]     quo_final_s;
    logic [XLEN-1:0]     rem_final_s;
    logic [XLEN-1:0]     calc_res_s;
    logic                last_step_s;

    // Shift {rem,quo} left by one and trial-subtract the divisor from the
    // upper 33 bits; the partial remainder is always below the divisor, so
    // the shifted value fits in 33 bits and a kept difference fits in 32.
    always_comb begin
        rem_shift_s = shreg_r[2*XLEN-1:XLEN-1];
        trial_s     = rem_shift_s - {1'b0, divisor_r};
        step_ok_s   = ~trial_s[XLEN];
        if (step_ok_s) begin
            rem_next_s = trial_s[XLEN-1:0];
        end else begin
            rem_next_s = rem_shift_s[XLEN-1:0];
        end
        quo_next_s  = {shreg_r[XLEN-2:0], step_ok_s};
        // Signs are latched as zero for unsigned ops, so no fix-up there.
        quo_final_s = neg_cond(quo_next_s, sign_dvd_r ^ sign_dvs_r);
        rem_final_s = neg_cond(rem_next_s, sign_dvd_r);
        calc_res_s  = op_r[1] ? rem_final_s : quo_final_s;
        last_step_s = (cnt_r == CNT_LAST);
    end

    // ---------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; flush wins over completing the last step.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_acc_s) begin
                    if (div_zero_s || overflow_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_CALC;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (bus.flush_i) begin
                    state_nxt_s = ST_IDLE;
                end else if (last_step_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_CALC;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM outputs; hold drops in DONE so the held instruction advances with
    // valid_o, and a flush in DONE suppresses valid_o in the same cycle.
    always_comb begin
        bus.hold_req_o = start_acc_s || (state_r == ST_CALC);
        bus.busy_o     = (state_r != ST_IDLE);
        if (state_r == ST_DONE) begin
            bus.valid_o = !bus.flush_i;
        end else begin
            bus.valid_o = 1'b0;
        end
        bus.result_o  = result_r;
        bus.rd_addr_o = rd_out_r;
    end

    // ---------------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------------

    // Operand latch, iteration shift register and registered result.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            op_r       <= 2'b00;
            rd_addr_r  <= 5'd0;
            sign_dvd_r <= 1'b0;
            sign_dvs_r <= 1'b0;
            divisor_r  <= ZERO_W;
            shreg_r    <= {2*XLEN{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            result_r   <= ZERO_W;
            rd_out_r   <= 5'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_acc_s) begin
                        op_r       <= bus.op_i;
                        rd_addr_r  <= bus.rd_addr_i;
                        sign_dvd_r <= dvd_neg_s;
                        sign_dvs_r <= dvs_neg_s;
                        divisor_r  <= dvs_abs_s;
                        shreg_r    <= {ZERO_W, dvd_abs_s};
                        cnt_r      <= {CNT_W{1'b0}};
                        if (div_zero_s || overflow_s) begin
                            result_r <= special_res_s;
                            rd_out_r <= bus.rd_addr_i;
                        end
                    end
                end
                ST_CALC: begin
                    if (!bus.flush_i) begin
                        shreg_r <= {rem_next_s, quo_next_s};
                        cnt_r   <= cnt_r + CNT_ONE;
                        // Result is registered on the way into DONE.
                        if (last_step_s) begin
                            result_r <= calc_res_s;
                            rd_out_r <= rd_addr_r;
                        end
                    end
                end
                default: begin
                    // DONE: nothing to update; result_o keeps its value.
                end
            endcase
        end
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle RV32M divider in the EX stage; executes DIV, DIVU, REM and REMU.
- While a division is in progress it raises hold_req_o, which drives the pipeline controller's ex_hold_flag_i. The controller then stalls PC, IF/ID, ID/EX and EX/MEM.
- When the result is ready it presents result_o, rd_addr_o and a one-cycle valid_o to the EX writeback mux.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 5, iteration counter width; equals log2(XLEN).

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  reset, synchronous, active-low.
- start_i  in  1  request a division; sampled only in IDLE.
- op_i  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- dividend_i  in  32  rs1 value.
- divisor_i  in  32  rs2 value.
- rd_addr_i  in  5  destination register.
- flush_i  in  1  abort the operation in flight, e.g. on a mispredict.
- hold_req_o  out  1  pipeline hold request to the controller.
- busy_o  out  1  state != IDLE.
- valid_o  out  1  result_o is valid this cycle.
- result_o  out  32  quotient or remainder.
- rd_addr_o  out  5  destination register of result_o.

Behaviour:
- Reset (rstn=0 at a clock edge):
  - State goes to IDLE.
  - valid_o=0, result_o=0, rd_addr_o=0, busy_o=0, hold_req_o=0.
  - Internal registers are cleared.
  - Reset overrides any operation in progress.
- States: IDLE, CALC, DONE.
- IDLE:
  - On start_i=1 and flush_i=0, latch op, rd_addr, operand signs, and |dividend| and |divisor|. Absolute values are taken only for DIV and REM; DIVU and REMU use the raw operands.
  - If divisor_i=0, go to DONE with the special result.
  - Else if op is DIV/REM and dividend_i=32'h8000_0000 and divisor_i=32'hFFFF_FFFF, go to DONE with the overflow result.
  - Otherwise go to CALC with cnt=0.
- CALC:
  - One restoring step per cycle on a 64-bit {rem,quo} shift register: shift left by 1, trial-subtract the divisor from the upper 33 bits, set the quotient LSB to 1 if the result is non-negative.
  - cnt increments each cycle. After the step with cnt=31, go to DONE, i.e. 32 cycles in CALC.
- DONE:
  - valid_o=1 for exactly one cycle; result_o and rd_addr_o are registered and stable in this cycle.
  - Next state is always IDLE.
  - A start_i in DONE is ignored; the pipeline is not held in DONE, so a new divide arrives in IDLE at the earliest.
- Result selection, applied on entry to DONE:
  - DIVU: quotient.
  - REMU: remainder.
  - DIV: quotient, negated if the operand signs differ.
  - REM: remainder, negated if the dividend is negative.
- Special results:
  - Divide by zero: quotient = 32'hFFFF_FFFF (both signed and unsigned); remainder = dividend_i unchanged.
  - Overflow: quotient = 32'h8000_0000, remainder = 0.
- Latency (start sampled at cycle T):
  - Normal operation: CALC from T+1 to T+32, valid_o at T+33.
  - Special cases: valid_o at T+1.
- hold_req_o is combinational: (state==IDLE && start_i && !flush_i) || state==CALC.
  - It is low in DONE, so the held instruction advances together with valid_o.
- flush_i:
  - In CALC or DONE, the next state is IDLE and valid_o is 0 in the next cycle.
  - In DONE, flush also forces valid_o=0 combinationally in the same cycle.
  - flush together with start in IDLE: the start is ignored and hold_req_o stays 0.
- start_i while busy_o=1 is ignored, with no effect on the operation in flight.
- result_o holds its last value after DONE; consumers qualify it with valid_o.

Test Plan:
- Reset mid-operation: rstn=0 at CALC cnt=10 -> next cycle IDLE; valid_o, busy_o, hold_req_o and result_o all 0.
- DIVU 100/7, rd=5: hold_req_o high at T..T+32 -> at T+33 valid_o=1, result_o=14, rd_addr_o=5; REMU with the same operands -> result_o=2.
- DIV -7/2 -> result_o=32'hFFFF_FFFD (-3); REM -7/2 -> 32'hFFFF_FFFF (-1); REM 7/-2 -> 1.
- Divide by zero, DIV 1234/0 -> valid_o at T+1 with 32'hFFFF_FFFF; REM 1234/0 -> 1234; hold_req_o high only in cycle T.
- Overflow, DIV 32'h8000_0000 / 32'hFFFF_FFFF -> valid_o at T+1 with 32'h8000_0000; REM with the same operands -> 0.
- flush_i at CALC cnt=20 -> IDLE next cycle, no valid_o ever. A new start two cycles later completes normally; a start issued during CALC is ignored.
